// File: rtl/exec_sequencer.sv
// Multi-cycle execution sequencer: walks one step- or switch-sourced instruction
// through FETCH/DECODE/EXEC/WB/DONE and emits the per-phase enable strobes.
module exec_sequencer (
   input  logic        clk,
   input  logic        reset,
   input  logic        step_pulse,
   input  logic        ext_pulse,
   input  logic [11:0] ext_instr,
   input  logic [11:0] mem_instr,
   output logic        ir_load,
   output logic        ir_src_ext,
   output logic        dm_rd_en,
   output logic        dm_wr_en,
   output logic        rf_we_en,
   output logic        pc_inc,
   output logic        busy,
   output logic        done_pulse,
   output logic        dropped,
   output logic [2:0]  phase,
   output logic [7:0]  inst_count
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_WB     = 3'd4,
      S_DONE   = 3'd5
   } state_t;

   typedef enum logic [1:0] {
      C_STORE = 2'b00,
      C_LOAD  = 2'b01,
      C_ALU   = 2'b10,
      C_NOP   = 2'b11
   } class_t;

   state_t      state_q, state_d;
   class_t      cls_q,   cls_d;
   logic        src_q,   src_d;
   logic        dropped_q, dropped_d;
   logic [7:0]  count_q, count_d;
   logic [11:0] sel_instr;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         cls_q     <= C_STORE;
         src_q     <= 1'b0;
         dropped_q <= 1'b0;
         count_q   <= '0;
      end else begin
         state_q   <= state_d;
         cls_q     <= cls_d;
         src_q     <= src_d;
         dropped_q <= dropped_d;
         count_q   <= count_d;
      end
   end

   assign sel_instr = src_q ? ext_instr : mem_instr;

   always_comb begin
      state_d   = state_q;
      cls_d     = cls_q;
      src_d     = src_q;
      dropped_d = dropped_q;
      count_d   = count_q;
      case (state_q)
         S_IDLE: begin
            // Step has priority; a simultaneous ext pulse is discarded and flagged.
            if (step_pulse) begin
               state_d = S_FETCH;
               src_d   = 1'b0;
               if (ext_pulse) dropped_d = 1'b1;
            end else if (ext_pulse) begin
               state_d = S_FETCH;
               src_d   = 1'b1;
            end
         end
         S_FETCH: begin
            cls_d   = class_t'(sel_instr[11:10]);
            state_d = S_DECODE;
         end
         S_DECODE: state_d = S_EXEC;
         S_EXEC:   state_d = (cls_q == C_LOAD || cls_q == C_ALU) ? S_WB : S_DONE;
         S_WB:     state_d = S_DONE;
         S_DONE: begin
            count_d = count_q + 8'd1;
            src_d   = 1'b0;
            state_d = S_IDLE;
         end
         default:  state_d = S_IDLE;
      endcase
      if (state_q != S_IDLE && (step_pulse || ext_pulse)) dropped_d = 1'b1;
   end

   always_comb begin
      ir_load    = 1'b0;
      dm_rd_en   = 1'b0;
      dm_wr_en   = 1'b0;
      rf_we_en   = 1'b0;
      pc_inc     = 1'b0;
      done_pulse = 1'b0;
      case (state_q)
         S_FETCH: ir_load = 1'b1;
         S_EXEC: begin
            dm_rd_en = (cls_q == C_LOAD);
            dm_wr_en = (cls_q == C_STORE);
         end
         S_WB:    rf_we_en = 1'b1;
         S_DONE: begin
            done_pulse = 1'b1;
            pc_inc     = ~src_q;
         end
         default: ;
      endcase
   end

   assign busy       = (state_q != S_IDLE);
   assign ir_src_ext = src_q;
   assign dropped    = dropped_q;
   assign phase      = state_q;
   assign inst_count = count_q;

endmodule

// File: tb/tb_exec_sequencer.sv
// Directed bench for exec_sequencer: per-cycle vector table plus hand-built
// sequences for busy drops, mid-instruction reset and counter wrap.
module tb_exec_sequencer;

   logic        clk = 1'b0;
   logic        reset, step_pulse, ext_pulse;
   logic [11:0] ext_instr, mem_instr;
   logic        ir_load, ir_src_ext, dm_rd_en, dm_wr_en, rf_we_en, pc_inc;
   logic        busy, done_pulse, dropped;
   logic [2:0]  phase;
   logic [7:0]  inst_count;

   int total = 0;
   int bad   = 0;
   int pc_seen = 0;
   int we_seen = 0;
   int onehot_bad = 0;

   exec_sequencer dut (
      .clk        (clk),
      .reset      (reset),
      .step_pulse (step_pulse),
      .ext_pulse  (ext_pulse),
      .ext_instr  (ext_instr),
      .mem_instr  (mem_instr),
      .ir_load    (ir_load),
      .ir_src_ext (ir_src_ext),
      .dm_rd_en   (dm_rd_en),
      .dm_wr_en   (dm_wr_en),
      .rf_we_en   (rf_we_en),
      .pc_inc     (pc_inc),
      .busy       (busy),
      .done_pulse (done_pulse),
      .dropped    (dropped),
      .phase      (phase),
      .inst_count (inst_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst, stp, ext;
      logic [11:0] ei, mi;
      logic [2:0]  ph;
      logic [7:0]  st;   // {ir_load, ir_src_ext, rd, wr, we, pc_inc, busy, done}
      logic        drp;
      logic [7:0]  cnt;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic rst, input logic stp, input logic ext,
                      input logic [11:0] ei, input logic [11:0] mi,
                      input logic [2:0] ph, input logic [7:0] st,
                      input logic drp, input logic [7:0] cnt);
      vec_t v;
      v.rst = rst; v.stp = stp; v.ext = ext; v.ei = ei; v.mi = mi;
      v.ph = ph; v.st = st; v.drp = drp; v.cnt = cnt;
      tbl.push_back(v);
   endtask

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if ($countones({ir_load, dm_rd_en, dm_wr_en, rf_we_en, pc_inc}) > 1) onehot_bad++;
      if (pc_inc) pc_seen++;
      if (rf_we_en) we_seen++;
   endtask

   task automatic do_reset();
      reset = 1'b1; step_pulse = 1'b0; ext_pulse = 1'b0;
      tick();
      reset = 1'b0;
   endtask

   function automatic logic [7:0] strobes();
      return {ir_load, ir_src_ext, dm_rd_en, dm_wr_en, rf_we_en, pc_inc, busy, done_pulse};
   endfunction

   initial begin
      int errs;
      int we0, pc0;

      reset = 1'b1; step_pulse = 1'b0; ext_pulse = 1'b0;
      ext_instr = '0; mem_instr = '0;

      //   rst  stp  ext  ext_i    mem_i    ph    strobes        drp  cnt
      add(1'b1,1'b0,1'b0,12'h000,12'h4A3,3'd0,8'b0000_0000,1'b0,8'd0);
      add(1'b0,1'b0,1'b0,12'h000,12'h4A3,3'd0,8'b0000_0000,1'b0,8'd0);
      add(1'b0,1'b1,1'b0,12'h000,12'h4A3,3'd1,8'b1000_0010,1'b0,8'd0);
      add(1'b0,1'b0,1'b0,12'h000,12'h4A3,3'd2,8'b0000_0010,1'b0,8'd0);
      add(1'b0,1'b0,1'b0,12'h000,12'h4A3,3'd3,8'b0010_0010,1'b0,8'd0);
      add(1'b0,1'b0,1'b0,12'h000,12'h4A3,3'd4,8'b0000_1010,1'b0,8'd0);
      add(1'b0,1'b0,1'b0,12'h000,12'h4A3,3'd5,8'b0000_0111,1'b0,8'd0);
      add(1'b0,1'b0,1'b0,12'h000,12'h4A3,3'd0,8'b0000_0000,1'b0,8'd1);
      add(1'b0,1'b0,1'b1,12'h0F2,12'h4A3,3'd1,8'b1100_0010,1'b0,8'd1);
      add(1'b0,1'b0,1'b0,12'h0F2,12'h4A3,3'd2,8'b0100_0010,1'b0,8'd1);
      add(1'b0,1'b0,1'b0,12'h0F2,12'h4A3,3'd3,8'b0101_0010,1'b0,8'd1);
      add(1'b0,1'b0,1'b0,12'h0F2,12'h4A3,3'd5,8'b0100_0011,1'b0,8'd1);
      add(1'b0,1'b0,1'b0,12'h0F2,12'h4A3,3'd0,8'b0000_0000,1'b0,8'd2);
      add(1'b0,1'b1,1'b1,12'h0F2,12'h800,3'd1,8'b1000_0010,1'b1,8'd2);
      add(1'b0,1'b0,1'b0,12'h0F2,12'h800,3'd2,8'b0000_0010,1'b1,8'd2);
      add(1'b0,1'b0,1'b0,12'h0F2,12'h800,3'd3,8'b0000_0010,1'b1,8'd2);
      add(1'b0,1'b0,1'b0,12'h0F2,12'h800,3'd4,8'b0000_1010,1'b1,8'd2);
      add(1'b0,1'b0,1'b0,12'h0F2,12'h800,3'd5,8'b0000_0111,1'b1,8'd2);
      add(1'b0,1'b0,1'b0,12'h0F2,12'h800,3'd0,8'b0000_0000,1'b1,8'd3);
      add(1'b1,1'b0,1'b0,12'h0F2,12'h800,3'd0,8'b0000_0000,1'b0,8'd0);
      add(1'b1,1'b1,1'b0,12'h0F2,12'h800,3'd0,8'b0000_0000,1'b0,8'd0);
      add(1'b0,1'b0,1'b0,12'h0F2,12'h800,3'd0,8'b0000_0000,1'b0,8'd0);

      foreach (tbl[i]) begin
         reset = tbl[i].rst; step_pulse = tbl[i].stp; ext_pulse = tbl[i].ext;
         ext_instr = tbl[i].ei; mem_instr = tbl[i].mi;
         tick();
         chk($sformatf("v%0d phase", i), phase, tbl[i].ph);
         chk($sformatf("v%0d strobes", i), strobes(), tbl[i].st);
         chk($sformatf("v%0d dropped", i), dropped, tbl[i].drp);
         chk($sformatf("v%0d count", i), inst_count, tbl[i].cnt);
      end
      reset = 1'b0; step_pulse = 1'b0; ext_pulse = 1'b0;

      // Step while busy (cycle 2 of ALU): ignored, not queued
      do_reset();
      mem_instr = 12'h800;
      step_pulse = 1'b1; tick(); step_pulse = 1'b0;
      tick();
      chk("busy_drop c2 phase", phase, 2);
      step_pulse = 1'b1; tick(); step_pulse = 1'b0;
      chk("busy_drop c3 phase", phase, 3);
      chk("busy_drop dropped", dropped, 1);
      tick(); chk("busy_drop c4 we", rf_we_en, 1);
      tick(); chk("busy_drop c5 phase", phase, 5);
      tick(); chk("busy_drop c6 phase", phase, 0);
      tick(); chk("busy_drop c7 phase", phase, 0);
      chk("busy_drop count", inst_count, 1);

      // Reset in EXEC of a load
      do_reset();
      mem_instr = 12'h4A3;
      step_pulse = 1'b1; tick(); step_pulse = 1'b0;
      tick(); tick();
      chk("rst_exec rd_en", dm_rd_en, 1);
      we0 = we_seen; pc0 = pc_seen;
      reset = 1'b1; tick(); reset = 1'b0;
      chk("rst_exec phase", phase, 0);
      chk("rst_exec strobes", strobes(), 0);
      chk("rst_exec count", inst_count, 0);
      repeat (4) tick();
      chk("rst_exec no we", we_seen - we0, 0);
      chk("rst_exec no pc_inc", pc_seen - pc0, 0);
      chk("rst_exec idle", phase, 0);

      // Pulse coinciding with DONE is dropped
      do_reset();
      mem_instr = 12'hC00;
      step_pulse = 1'b1; tick(); step_pulse = 1'b0;
      tick(); tick(); tick();
      chk("done_drop done", done_pulse, 1);
      step_pulse = 1'b1; tick(); step_pulse = 1'b0;
      chk("done_drop phase", phase, 0);
      chk("done_drop dropped", dropped, 1);
      tick();
      chk("done_drop stays idle", phase, 0);

      // 256 back-to-back NOPs, each accepted in the first IDLE cycle
      do_reset();
      pc0 = pc_seen;
      errs = 0;
      mem_instr = 12'hC00;
      for (int i = 0; i < 256; i++) begin
         step_pulse = 1'b1; tick(); step_pulse = 1'b0;
         tick(); tick(); tick(); tick();
         if (phase != 3'd0 || inst_count != 8'((i + 1) & 255)) errs++;
      end
      chk("nop256 per-iter errors", errs, 0);
      chk("nop256 count wrap", inst_count, 0);
      chk("nop256 pc_inc pulses", pc_seen - pc0, 256);
      chk("nop256 dropped", dropped, 0);

      chk("strobe one-hot violations", onehot_bad, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/exec_sequencer.md
# exec_sequencer

Multi-cycle execution sequencer for the 12-bit button-driven processor. It accepts one-cycle debounced step (next program instruction) and external-execute (switch instruction) pulses, then walks one instruction through FETCH, DECODE, EXEC/MEM, WB and DONE. In each phase it emits the single-cycle enable strobes that gate the PC, instruction register, data memory and register file. It sits between the debouncers and the PC / instReg / dataMem / datapath blocks, and replaces the ad-hoc increment/set latching in the top level.

## Interface
- No parameters; all widths fixed.
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; returns block to IDLE
- step_pulse  in  1  one-cycle debounced pulse: execute the instruction at the current PC
- ext_pulse  in  1  one-cycle debounced pulse: execute ext_instr
- ext_instr  in  12  switch instruction
- mem_instr  in  12  instruction memory output at the current PC
- ir_load  out  1  one-cycle load strobe for the instruction register
- ir_src_ext  out  1  IR input mux select: 1 = ext_instr, 0 = mem_instr; held from acceptance until IDLE
- dm_rd_en  out  1  data memory read strobe (load class)
- dm_wr_en  out  1  data memory write strobe (store class)
- rf_we_en  out  1  gate ANDed with the controller's RF_we
- pc_inc  out  1  one-cycle PC increment (step-sourced instructions only)
- busy  out  1  high in every state except IDLE
- done_pulse  out  1  one cycle, in DONE
- dropped  out  1  sticky; set when a pulse is ignored; cleared only by reset
- phase  out  3  state encoding for display: IDLE=0, FETCH=1, DECODE=2, EXEC=3, WB=4, DONE=5
- inst_count  out  8  retired-instruction counter

## Operation
- Instruction class comes from bits [11:10] of the selected source, latched in FETCH:
  - 00 store
  - 01 load
  - 10 ALU
  - 11 NOP
- Acceptance happens only in IDLE.
  - step_pulse → FETCH with src=0.
  - ext_pulse alone → FETCH with src=1.
  - Both in the same cycle: step wins, ext is discarded, dropped is set.
- Pulses arriving while busy are ignored and set dropped. They are not queued.
- FETCH: ir_load=1; class latched from ext_instr or mem_instr per src. Next state is DECODE.
- DECODE: no strobes. Next state is EXEC.
- EXEC:
  - load: dm_rd_en=1.
  - store: dm_wr_en=1.
  - ALU/NOP: no strobes.
  - Next state is WB for load/ALU, DONE for store/NOP.
- WB: rf_we_en=1. Next state is DONE.
- DONE:
  - done_pulse=1.
  - pc_inc=1 only if src=0.
  - inst_count increments, wrapping 255→0, for every class including NOP.
  - Next state is IDLE.
- All strobes are Moore outputs, decoded from the state register only. At most one of ir_load, dm_rd_en, dm_wr_en, rf_we_en, pc_inc is high in any cycle.
- ir_src_ext is a register, so the IR mux stays stable through the whole instruction.

## Timing
- Reset values, one cycle after reset is sampled high:
  - phase=0; busy=0; all strobes 0.
  - ir_src_ext=0; dropped=0; inst_count=0.
- Reset mid-instruction: the pending strobes are never issued, no PC increment occurs, and inst_count is not incremented.
- Reset overrides a pulse arriving in the same cycle.
- Latency, with the accepting pulse sampled at edge 0:
  - FETCH is active in cycle 1, DECODE in 2, EXEC in 3.
  - load/ALU: WB in cycle 4, DONE in 5, IDLE in 6.
  - store/NOP: DONE in cycle 4, IDLE in 5.
- Throughput: a new pulse can be accepted in the first IDLE cycle. A pulse coinciding with DONE is dropped.
- dm_rd_en precedes rf_we_en by exactly one cycle, matching the synchronous dataMem read.
- The instruction register is written at the end of FETCH. Controller outputs are valid from DECODE onward.

## Test plan
- Reset, then step_pulse with mem_instr=12'h4A3 (load):
  - strobe sequence is ir_load@1, dm_rd_en@3, rf_we_en@4, done_pulse+pc_inc@5;
  - busy is high for cycles 1–5; inst_count=1.
- ext_pulse with ext_instr=12'h0F2 (store):
  - ir_src_ext=1 for cycles 1–4; dm_wr_en@3; done_pulse@4;
  - no pc_inc, no rf_we_en.
- step_pulse and ext_pulse in the same cycle with mem_instr=12'h800 (ALU):
  - sequence is step-sourced (pc_inc@5); dropped=1.
- step_pulse at cycle 2 of an ALU instruction:
  - ignored; sequence unchanged; dropped=1; returns to IDLE at cycle 6.
- reset asserted in EXEC of a load:
  - next cycle phase=0 and all strobes 0;
  - rf_we_en and pc_inc never fire; inst_count unchanged.
- 256 back-to-back NOP (12'hC00) step instructions:
  - inst_count wraps to 0; exactly 256 pc_inc pulses; dropped stays 0.
